stream_feeder: RTL and testbench
================================

STREAM_FEEDER -- requirements
Module: stream_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the stream word width; only 32 is supported.
REQ-002 SHALL have parameter NUM_WORDS, default 1024, meaning the words per frame (1..65535).
REQ-003 SHALL have parameter SEED, default 32'h00000001, meaning the first word of each frame (nonzero).
REQ-004 SHALL have parameter GAP, default 0, meaning the idle cycles inserted after each consumed word (0..15).
REQ-005 SHALL have port ap_clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 SHALL have port ap_rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port start  in  1  single-cycle frame request.
REQ-008 SHALL have port in_read  in  1  kernel ap_fifo read strobe.
REQ-009 SHALL have port in_dout  out  DATA_W  current stream word.
REQ-010 SHALL have port in_empty_n  out  1  word available (ap_fifo semantics).
REQ-011 SHALL have port done  out  1  frame complete, level.
REQ-012 SHALL have port word_cnt  out  16  words consumed in the current frame.
REQ-013 SHALL have port checksum  out  32  running sum of consumed words.

Function
REQ-014 SHALL implement states IDLE, RUN, GAPW, DONE, all outputs registered.
REQ-015 SHALL go IDLE->RUN on start=1; the next cycle SHALL show in_empty_n=1 and in_dout=SEED.
REQ-016 SHALL count a consume as a rising edge with in_empty_n=1 and in_read=1; in_read with in_empty_n=0 SHALL be ignored.
REQ-017 SHALL, on consume, increment word_cnt and step in_dout by one LFSR step: next=(x>>1)^(x[0]?32'h80200003:0).
REQ-018 SHALL, on consume with GAP=0 and word_cnt+1<NUM_WORDS, stay in RUN with in_empty_n=1 and the new word the following cycle (one word per cycle sustained).
REQ-019 SHALL, on consume with GAP>0 and word_cnt+1<NUM_WORDS, enter GAPW with in_empty_n=0 for exactly GAP cycles, then return to RUN with in_empty_n=1.
REQ-020 SHALL, on the consume making word_cnt==NUM_WORDS, enter DONE with in_empty_n=0 and done=1 the next cycle.
REQ-021 SHALL ignore start in RUN and GAPW.
REQ-022 SHALL, on start in DONE, clear done, word_cnt and checksum, reload SEED and enter RUN (same timing as REQ-015).
REQ-023 SHALL hold in_dout stable while in_empty_n=1 and no consume occurs.
REQ-024 SHALL wrap checksum modulo 2^32.

Reset
REQ-025 SHALL, while ap_rst=1 at a rising edge, force state IDLE, in_empty_n=0, in_dout=0, done=0, word_cnt=0, checksum=0, overriding start and in_read.
REQ-026 SHALL, on reset mid-frame, abandon the frame; a new start SHALL begin at SEED.

Configuration
REQ-027 SHALL use macro FEEDER_CHECKSUM_EN; when defined, checksum SHALL add each consumed in_dout on its consume edge.
REQ-028 SHALL, without FEEDER_CHECKSUM_EN, tie checksum to 0 with no accumulator logic; the port SHALL remain.

Structure
REQ-029 SHALL place the state enum, the LFSR polynomial constant 32'h80200003 and the word_cnt width in package feeder_pkg.
REQ-030 SHALL implement the LFSR step in sub-module lfsr32 (load, step, seed in; value out).

Verification
REQ-031 SHALL cover: SEED=1, GAP=0, in_read held 1 after start -> in_dout 0x00000001, 0x80200003, 0xC0300002 on consecutive cycles.
REQ-032 SHALL cover: NUM_WORDS=4, GAP=0, read always 1 -> exactly 4 consumes, done=1 and in_empty_n=0 in the cycle after the 4th, word_cnt=4.
REQ-033 SHALL cover: GAP=3, read always 1 -> in_empty_n pattern 1,0,0,0,1 between consumes; in_read during the gap has no effect.
REQ-034 SHALL cover: in_read=0 for 10 cycles in RUN -> in_dout and word_cnt unchanged; start pulse mid-frame is ignored.
REQ-035 SHALL cover: ap_rst=1 after 2 consumes -> all outputs 0 next cycle; new start gives in_dout=0x00000001.
REQ-036 SHALL cover: FEEDER_CHECKSUM_EN defined, NUM_WORDS=3, SEED=1 -> checksum=0x40500006 at done; undefined -> checksum=0.

Source files
------------

// File: rtl/feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : feeder_pkg
// Brief    : Shared types and constants for the stream_feeder slice.
// Revision : 1.0 - initial release
// ============================================================================
package feeder_pkg;

    localparam int          c_cnt_w     = 16;
    localparam logic [31:0] c_lfsr_poly = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAPW = 2'd2,
        DONE = 2'd3
    } state_t;

    // Right-shifting Galois step; the polynomial taps are folded in when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? c_lfsr_poly : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr32.sv
`default_nettype none
// ============================================================================
// Module   : lfsr32
// Brief    : 32-bit Galois LFSR register with synchronous load and step.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr32
    import feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_seed,
    output logic [31:0] o_value
);

    logic [31:0] r_value;

    // Load wins over step so a frame restart always begins exactly at the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_seed;
        end else if (i_step) begin
            r_value <= lfsr_step(r_value);
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : stream_feeder
// Brief    : ap_fifo-style LFSR word source with optional inter-word gap.
//            Build option FEEDER_CHECKSUM_EN enables the running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module stream_feeder
    import feeder_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          NUM_WORDS = 1024,
    parameter logic [31:0] SEED      = 32'h00000001,
    parameter int          GAP       = 0
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               start,
    input  logic               in_read,
    output logic [DATA_W-1:0]  in_dout,
    output logic               in_empty_n,
    output logic               done,
    output logic [c_cnt_w-1:0] word_cnt,
    output logic [31:0]        checksum
);

    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(NUM_WORDS);
    localparam int                 c_gap_m1   = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [3:0]         c_gap_init = 4'(c_gap_m1);

    state_t             r_state, w_state_nxt;
    logic               r_empty_n, w_empty_n_nxt;
    logic               r_done, w_done_nxt;
    logic [c_cnt_w-1:0] r_word_cnt, w_word_cnt_nxt;
    logic [3:0]         r_gap_cnt, w_gap_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_consume;
    logic               w_load;
    logic               w_step;

    assign w_consume = r_empty_n & in_read;
    assign w_cnt_inc = r_word_cnt + 1'b1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= IDLE;
            r_empty_n  <= 1'b0;
            r_done     <= 1'b0;
            r_word_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_empty_n  <= w_empty_n_nxt;
            r_done     <= w_done_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_empty_n_nxt  = r_empty_n;
        w_done_nxt     = r_done;
        w_word_cnt_nxt = r_word_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_load         = 1'b0;
        w_step         = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt    = RUN;
                    w_load         = 1'b1;
                    w_empty_n_nxt  = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_word_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (w_consume) begin
                    w_step         = 1'b1;
                    w_word_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_last) begin
                        w_state_nxt   = DONE;
                        w_empty_n_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else if (GAP != 0) begin
                        w_state_nxt   = GAPW;
                        w_empty_n_nxt = 1'b0;
                        w_gap_cnt_nxt = c_gap_init;
                    end
                end
            end
            GAPW: begin
                // Counter holds the number of further idle cycles still owed.
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt   = RUN;
                    w_empty_n_nxt = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_empty_n_nxt = 1'b0;
            end
        endcase
    end

    lfsr32 u_lfsr (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_seed  (SEED),
        .o_value (in_dout)
    );

`ifdef FEEDER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Accumulates the word being consumed, i.e. the value before the LFSR steps.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || w_load) begin
            r_checksum <= '0;
        end else if (w_step) begin
            r_checksum <= r_checksum + 32'(in_dout);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign in_empty_n = r_empty_n;
    assign done       = r_done;
    assign word_cnt   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_feeder
// Brief    : Self-checking bench; three feeder configurations share one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_feeder;

`ifdef FEEDER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    typedef struct {
        bit          avail;
        bit          done;
        int unsigned cnt;
        logic [31:0] word;
        logic [31:0] sum;
        int          gap_left;
    } model_t;

    logic clk = 1'b0;
    logic ap_rst = 1'b1;
    logic start = 1'b0;
    logic in_read = 1'b0;

    logic [31:0] a_dout, b_dout, c_dout;
    logic        a_empty, b_empty, c_empty;
    logic        a_done, b_done, c_done;
    logic [15:0] a_cnt, b_cnt, c_cnt;
    logic [31:0] a_sum, b_sum, c_sum;

    model_t ma, mb, mc;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_feeder #(.DATA_W(32), .NUM_WORDS(4), .SEED(32'h1), .GAP(0)) u_a (
        .ap_clk(clk), .ap_rst(ap_rst), .start(start), .in_read(in_read),
        .in_dout(a_dout), .in_empty_n(a_empty), .done(a_done),
        .word_cnt(a_cnt), .checksum(a_sum));

    stream_feeder #(.DATA_W(32), .NUM_WORDS(6), .SEED(32'h1), .GAP(3)) u_b (
        .ap_clk(clk), .ap_rst(ap_rst), .start(start), .in_read(in_read),
        .in_dout(b_dout), .in_empty_n(b_empty), .done(b_done),
        .word_cnt(b_cnt), .checksum(b_sum));

    stream_feeder #(.DATA_W(32), .NUM_WORDS(3), .SEED(32'h1), .GAP(0)) u_c (
        .ap_clk(clk), .ap_rst(ap_rst), .start(start), .in_read(in_read),
        .in_dout(c_dout), .in_empty_n(c_empty), .done(c_done),
        .word_cnt(c_cnt), .checksum(c_sum));

    function automatic logic [31:0] lfsr_ref(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] exp_sum(input model_t m);
        return CS_EN ? m.sum : 32'h0;
    endfunction

    // Frame-level behaviour: a word is either offered or not; gaps are idle-cycle debts.
    function automatic model_t model_step(input model_t m, input int unsigned n, input int gap,
                                          input bit rs, input bit st, input bit rd);
        model_t r;
        r = m;
        if (rs) begin
            r = '{default: 0};
        end else if (m.avail) begin
            if (rd) begin
                r.sum  = m.sum + m.word;
                r.word = lfsr_ref(m.word);
                r.cnt  = m.cnt + 1;
                if (r.cnt == n) begin
                    r.avail = 1'b0;
                    r.done  = 1'b1;
                end else if (gap > 0) begin
                    r.avail    = 1'b0;
                    r.gap_left = gap;
                end
            end
        end else if (m.gap_left > 0) begin
            r.gap_left = m.gap_left - 1;
            if (r.gap_left == 0) r.avail = 1'b1;
        end else if (st) begin
            r.word  = 32'h1;
            r.sum   = 32'h0;
            r.cnt   = 0;
            r.done  = 1'b0;
            r.avail = 1'b1;
        end
        return r;
    endfunction

    task automatic tick(input bit st, input bit rd, input bit rs);
        start   = st;
        in_read = rd;
        ap_rst  = rs;
        @(posedge clk);
        ma = model_step(ma, 4, 0, rs, st, rd);
        mb = model_step(mb, 6, 3, rs, st, rd);
        mc = model_step(mc, 3, 0, rs, st, rd);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 1);
        tick(0, 0, 1);
        checks++;
        if ({a_dout, a_empty, a_done, a_cnt, a_sum} !== 82'b0) begin
            errors++;
            $display("FAIL reset_a got=%h/%b/%b/%h/%h required all zero", a_dout, a_empty, a_done, a_cnt, a_sum);
        end
        checks++;
        if ({b_dout, b_empty, b_done, b_cnt, b_sum} !== 82'b0) begin
            errors++;
            $display("FAIL reset_b got=%h/%b/%b/%h/%h required all zero", b_dout, b_empty, b_done, b_cnt, b_sum);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] c_req;
        c_req = CS_EN ? 32'h40500006 : 32'h0;
        tick(1, 0, 0);
        checks++;
        if (a_empty !== 1'b1 || a_dout !== 32'h00000001) begin
            errors++;
            $display("FAIL seq_first got empty=%b dout=%h required 1/00000001", a_empty, a_dout);
        end
        tick(0, 1, 0);
        checks++;
        if (a_dout !== 32'h80200003 || a_cnt !== 16'd1) begin
            errors++;
            $display("FAIL seq_second got dout=%h cnt=%0d required 80200003/1", a_dout, a_cnt);
        end
        tick(0, 1, 0);
        checks++;
        if (a_dout !== 32'hC0300002 || a_cnt !== 16'd2 || a_empty !== 1'b1) begin
            errors++;
            $display("FAIL seq_third got dout=%h cnt=%0d empty=%b required c0300002/2/1", a_dout, a_cnt, a_empty);
        end
        tick(0, 1, 0);
        checks++;
        if (c_done !== 1'b1 || c_empty !== 1'b0 || c_cnt !== 16'd3 || c_sum !== c_req) begin
            errors++;
            $display("FAIL csum_done got done=%b empty=%b cnt=%0d sum=%h required 1/0/3/%h", c_done, c_empty, c_cnt, c_sum, c_req);
        end
        tick(0, 1, 0);
        checks++;
        if (a_done !== 1'b1 || a_empty !== 1'b0 || a_cnt !== 16'd4 || a_sum !== exp_sum(ma)) begin
            errors++;
            $display("FAIL frame_done got done=%b empty=%b cnt=%0d sum=%h required 1/0/4/%h", a_done, a_empty, a_cnt, a_sum, exp_sum(ma));
        end
        repeat (3) tick(0, 1, 0);
        checks++;
        if (a_done !== 1'b1 || a_cnt !== 16'd4 || c_cnt !== 16'd3) begin
            errors++;
            $display("FAIL after_done got done=%b cnt_a=%0d cnt_c=%0d required 1/4/3", a_done, a_cnt, c_cnt);
        end
    endtask

    task automatic test_gap();
        tick(0, 0, 1);
        tick(1, 0, 0);
        checks++;
        if (b_empty !== 1'b1 || b_dout !== 32'h1) begin
            errors++;
            $display("FAIL gap_start got empty=%b dout=%h required 1/00000001", b_empty, b_dout);
        end
        for (int i = 1; i <= 13; i++) begin
            tick(0, 1, 0);
            checks++;
            if (b_empty !== ((i % 4) == 0) || b_cnt !== 16'((i + 3) / 4)) begin
                errors++;
                $display("FAIL gap_pattern i=%0d got empty=%b cnt=%0d required %b/%0d", i, b_empty, b_cnt, (i % 4) == 0, (i + 3) / 4);
            end
        end
    endtask

    task automatic test_hold();
        tick(0, 0, 1);
        tick(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0);
            checks++;
            if (a_dout !== 32'h1 || a_cnt !== 16'd0 || a_empty !== 1'b1) begin
                errors++;
                $display("FAIL hold i=%0d got dout=%h cnt=%0d empty=%b required 00000001/0/1", i, a_dout, a_cnt, a_empty);
            end
        end
        tick(0, 1, 0);
        tick(1, 0, 0);
        checks++;
        if (a_dout !== 32'h80200003 || a_cnt !== 16'd1 || a_empty !== 1'b1 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored got dout=%h cnt=%0d empty=%b done=%b required 80200003/1/1/0", a_dout, a_cnt, a_empty, a_done);
        end
    endtask

    task automatic test_reset_midframe();
        tick(0, 0, 1);
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 1, 0);
        tick(1, 1, 1);
        checks++;
        if ({a_dout, a_empty, a_done, a_cnt, a_sum} !== 82'b0) begin
            errors++;
            $display("FAIL midframe_rst got=%h/%b/%b/%h/%h required all zero", a_dout, a_empty, a_done, a_cnt, a_sum);
        end
        tick(1, 0, 0);
        checks++;
        if (a_dout !== 32'h1 || a_empty !== 1'b1 || a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL restart got dout=%h empty=%b cnt=%0d required 00000001/1/0", a_dout, a_empty, a_cnt);
        end
    endtask

    task automatic test_random();
        bit st, rd, rs;
        for (int cyc = 0; cyc < 600; cyc++) begin
            st = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 199) == 0);
            tick(st, rd, rs);
            checks++;
            if ({a_dout, a_empty, a_done, a_cnt, a_sum} !== {ma.word, ma.avail, ma.done, 16'(ma.cnt), exp_sum(ma)}) begin
                errors++;
                $display("FAIL rand_a cyc=%0d got=%h/%b/%b/%h/%h required=%h/%b/%b/%h/%h", cyc, a_dout, a_empty, a_done, a_cnt, a_sum,
                         ma.word, ma.avail, ma.done, 16'(ma.cnt), exp_sum(ma));
            end
            checks++;
            if ({b_dout, b_empty, b_done, b_cnt, b_sum} !== {mb.word, mb.avail, mb.done, 16'(mb.cnt), exp_sum(mb)}) begin
                errors++;
                $display("FAIL rand_b cyc=%0d got=%h/%b/%b/%h/%h required=%h/%b/%b/%h/%h", cyc, b_dout, b_empty, b_done, b_cnt, b_sum,
                         mb.word, mb.avail, mb.done, 16'(mb.cnt), exp_sum(mb));
            end
            checks++;
            if ({c_dout, c_empty, c_done, c_cnt, c_sum} !== {mc.word, mc.avail, mc.done, 16'(mc.cnt), exp_sum(mc)}) begin
                errors++;
                $display("FAIL rand_c cyc=%0d got=%h/%b/%b/%h/%h required=%h/%b/%b/%h/%h", cyc, c_dout, c_empty, c_done, c_cnt, c_sum,
                         mc.word, mc.avail, mc.done, 16'(mc.cnt), exp_sum(mc));
            end
        end
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        mc = '{default: 0};
        test_reset();
        test_sequence();
        test_gap();
        test_hold();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
